pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Fetch-side program counter stage that sits directly upstream of the instruction fetch unit. It holds the architectural PC (reset 0x0000_3000) and computes the next PC from decoded control: sequential, conditional branch, j/jal, or jr. The PC drives the word-indexed instruction memory. The block also flags illegal fetch targets and counts retired fetches for the bench.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset; base of instruction memory
IM_WORDS, 4096, instruction memory depth in words; legal PC range is [RESET_PC, RESET_PC + 4*IM_WORDS)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC and counter this cycle
npc_sel  input  2  next-PC source: 00 seq, 01 branch, 10 jump imm26, 11 jump register
br_type  input  2  branch compare: 00 beq, 01 bne, 10 blez(rs), 11 bgtz(rs)
imm16  input  16  branch offset field of current instruction
imm26  input  26  jump index field of current instruction
rs_data  input  32  GPR[rs] value (compare operand / jr target)
rt_data  input  32  GPR[rt] value (compare operand)
pc  output  32  current PC, registered
pc_plus4  output  32  pc + 4, combinational (jal link value; no delay slot)
npc  output  32  computed next PC, combinational
taken  output  1  branch condition true and npc_sel==01, combinational
fault  output  1  sticky illegal-target flag, registered
fault_addr  output  32  offending target captured at fault, registered
retired_cnt  output  32  count of PC advances since reset, registered

Behaviour:
- Reset (synchronous, active-high, overrides everything): pc=RESET_PC, fault=0, fault_addr=0, retired_cnt=0.
- Target computation (combinational, 32-bit wrap-around arithmetic):
  - seq: pc+4.
  - branch: taken ? pc+4+(sign_ext(imm16)<<2) : pc+4.
  - jump: {pc_plus4[31:28], imm26, 2'b00}.
  - jr: rs_data unmodified.
  - Compares are signed for blez/bgtz, bitwise equality for beq/bne.
- Legality of npc: npc[1:0]==0 and RESET_PC <= npc < RESET_PC+4*IM_WORDS (unsigned compare).
- Per rising edge, priority order:
  - reset.
  - fault==1: all state frozen until reset.
  - stall==1: pc, retired_cnt and fault unchanged. No legality check.
  - npc illegal: pc unchanged, fault<=1, fault_addr<=npc, retired_cnt unchanged.
  - otherwise: pc<=npc, retired_cnt<=retired_cnt+1 (wraps at 2^32).
- Latency: one cycle from control inputs to new pc. npc, taken and pc_plus4 follow inputs in the same cycle.
- Modeled as a two-state FSM: RUN, FAULTED. RUN->FAULTED on an unstalled illegal npc. FAULTED->RUN only by reset.
- Last legal word (pc=RESET_PC+4*IM_WORDS-4) with seq select faults; fault_addr=RESET_PC+4*IM_WORDS.
- Reset asserted together with stall or a fault condition: reset wins. The result is the reset values above.

Decomposition:
- Shared constants in define.v: NPC_SEQ/NPC_BR/NPC_J/NPC_JR codes, BR_BEQ/BR_BNE/BR_BLEZ/BR_BGTZ codes, RESET_PC value.
- One natural sub-module: npc_calc. It is purely combinational: target mux, branch compare, legality check.
- pc_unit holds the registers and the FSM.

Test Plan:
- Reset, then 3 cycles npc_sel=00 -> pc 0x3000,0x3004,0x3008,0x300C; retired_cnt=3.
- At pc=0x3010: beq, rs=rt=5, imm16=0xFFFC -> taken=1, next pc=0x3004. Then bne with equal operands -> taken=0, next pc=pc+4.
- At pc=0x3020: npc_sel=10, imm26=0x0000C40 -> next pc=0x00003100. pc_plus4=0x3024 during jump cycle.
- jr rs_data=0x3006 -> fault=1, fault_addr=0x3006, pc holds 0x3020 for 5+ cycles; reset -> pc=0x3000, fault=0.
- stall held 4 cycles with an illegal jr target present -> no fault, pc and retired_cnt unchanged. Release stall with target 0x3040 -> pc=0x3040.
- bgtz rs=0x80000000 -> not taken. blez rs=0 -> taken. jr 0x7000 -> fault. Reset and stall asserted together -> pc=0x3000.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared encodings and helpers for the fetch-side PC stage.
//   npc_sel_e  : next-PC source select (seq / branch / jump imm26 / jump register)
//   br_type_e  : branch compare kind (beq / bne / blez / bgtz)
//   pc_state_e : RUN / FAULTED state of the PC unit
//   RESET_PC_DEF, IM_WORDS_DEF : default reset PC and instruction memory depth
//   br_offset  : sign-extended, word-scaled branch displacement
//   br_cond    : branch condition evaluation
package pc_unit_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  typedef enum logic [1:0] {
    BR_BEQ  = 2'b00,
    BR_BNE  = 2'b01,
    BR_BLEZ = 2'b10,
    BR_BGTZ = 2'b11
  } br_type_e;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_FAULTED = 1'b1
  } pc_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int          IM_WORDS_DEF = 4096;

  // imm16 sign-extended to 32 bits and shifted left by two (word offset).
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // beq/bne compare bit patterns; blez/bgtz treat rs as two's complement.
  function automatic logic br_cond(input logic [1:0] typ,
                                   input logic [31:0] rs,
                                   input logic [31:0] rt);
    logic signed [31:0] rs_s;
    logic               c;
    rs_s = $signed(rs);
    c    = 1'b0;
    case (typ)
      BR_BEQ:  c = (rs == rt);
      BR_BNE:  c = (rs != rt);
      BR_BLEZ: c = (rs_s <= 32'sd0);
      BR_BGTZ: c = (rs_s >  32'sd0);
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pc_unit_npc_calc.sv
// pc_unit_npc_calc: purely combinational next-PC computation.
//   pc        in  : current PC
//   npc_sel   in  : next-PC source select
//   br_type   in  : branch compare kind
//   imm16     in  : branch offset field
//   imm26     in  : jump index field
//   rs_data   in  : GPR[rs] (compare operand / jr target)
//   rt_data   in  : GPR[rt] (compare operand)
//   pc_plus4  out : pc + 4
//   npc       out : selected next PC
//   taken     out : branch selected and its condition holds
//   legal     out : npc is word aligned and inside instruction memory
module pc_unit_npc_calc
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IM_WORDS = IM_WORDS_DEF
) (
  input  logic [31:0] pc,
  input  logic [1:0]  npc_sel,
  input  logic [1:0]  br_type,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] pc_plus4,
  output logic [31:0] npc,
  output logic        taken,
  output logic        legal
);

  // Bounds are held in 33 bits so that a memory region ending exactly at
  // 2^32 does not wrap the upper limit back to zero.
  localparam logic [32:0] LIM_LO = {1'b0, RESET_PC};
  localparam logic [32:0] LIM_HI = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

  logic        cond;
  logic [32:0] npc_ext;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    cond     = br_cond(br_type, rs_data, rt_data);
    taken    = (npc_sel == NPC_BR) && cond;

    npc = pc_plus4;
    case (npc_sel)
      NPC_SEQ: npc = pc_plus4;
      NPC_BR:  npc = taken ? (pc_plus4 + br_offset(imm16)) : pc_plus4;
      NPC_J:   npc = {pc_plus4[31:28], imm26, 2'b00};
      NPC_JR:  npc = rs_data;
      default: npc = pc_plus4;
    endcase

    npc_ext = {1'b0, npc};
    legal   = (npc[1:0] == 2'b00) && (npc_ext >= LIM_LO) && (npc_ext < LIM_HI);
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: architectural program counter with illegal-target trapping.
//   clk         in  : system clock, rising edge
//   reset       in  : synchronous active-high reset
//   stall       in  : hold PC and counter this cycle
//   npc_sel     in  : next-PC source (00 seq, 01 branch, 10 j imm26, 11 jr)
//   br_type     in  : branch compare (00 beq, 01 bne, 10 blez, 11 bgtz)
//   imm16       in  : branch offset field
//   imm26       in  : jump index field
//   rs_data     in  : GPR[rs]
//   rt_data     in  : GPR[rt]
//   pc          out : current PC (registered)
//   pc_plus4    out : pc + 4 (combinational, jal link value)
//   npc         out : next PC (combinational)
//   taken       out : branch taken (combinational)
//   fault       out : sticky illegal-target flag (registered)
//   fault_addr  out : target that caused the fault (registered)
//   retired_cnt out : number of PC advances since reset (registered)
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IM_WORDS = IM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic [1:0]  br_type,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] npc,
  output logic        taken,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] retired_cnt
);

  logic        legal;
  pc_state_e   state_p0;
  logic [31:0] pc_p0;
  logic        fault_p0;
  logic [31:0] fault_addr_p0;
  logic [31:0] retired_p0;

  pc_unit_npc_calc #(
    .RESET_PC (RESET_PC),
    .IM_WORDS (IM_WORDS)
  ) u_npc_calc (
    .pc       (pc_p0),
    .npc_sel  (npc_sel),
    .br_type  (br_type),
    .imm16    (imm16),
    .imm26    (imm26),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .pc_plus4 (pc_plus4),
    .npc      (npc),
    .taken    (taken),
    .legal    (legal)
  );

  // ---- stage p0: PC register and RUN/FAULTED state ----
  // Once FAULTED, nothing moves until reset; a stalled cycle never checks
  // legality, so an illegal target sitting on the bus while stalled is benign.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0      <= ST_RUN;
      pc_p0         <= RESET_PC;
      fault_p0      <= 1'b0;
      fault_addr_p0 <= 32'd0;
      retired_p0    <= 32'd0;
    end else begin
      case (state_p0)
        ST_RUN: begin
          if (!stall) begin
            if (!legal) begin
              state_p0      <= ST_FAULTED;
              fault_p0      <= 1'b1;
              fault_addr_p0 <= npc;
            end else begin
              pc_p0      <= npc;
              retired_p0 <= retired_p0 + 32'd1;
            end
          end
        end
        ST_FAULTED: begin
          state_p0 <= ST_FAULTED;
        end
        default: begin
          state_p0 <= ST_FAULTED;
          fault_p0 <= 1'b1;
        end
      endcase
    end
  end

  assign pc          = pc_p0;
  assign fault       = fault_p0;
  assign fault_addr  = fault_addr_p0;
  assign retired_cnt = retired_p0;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: table-driven vectors with an expected-state
// scoreboard queue, plus hand-written multi-cycle sequences.
module tb_pc_unit;

  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam logic [31:0] LIM = 32'h0000_7000;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [1:0]  npc_sel, br_type;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_data, rt_data;
  logic [31:0] pc, pc_plus4, npc, fault_addr, retired_cnt;
  logic        taken, fault;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .npc_sel     (npc_sel),
    .br_type     (br_type),
    .imm16       (imm16),
    .imm26       (imm26),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .npc         (npc),
    .taken       (taken),
    .fault       (fault),
    .fault_addr  (fault_addr),
    .retired_cnt (retired_cnt)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic [1:0]  sel;
    logic [1:0]  br;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_pc;
    logic        exp_taken;
    logic        exp_fault;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        fault;
    logic [31:0] faddr;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl1[$];
  vec_t tbl2[$];

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic        m_known = 1'b0;
  logic [31:0] m_pc, m_faddr, m_cnt;
  logic        m_fault;

  function automatic vec_t mk(input logic rst, input logic stl, input logic [1:0] sel,
                              input logic [1:0] br, input logic [15:0] i16,
                              input logic [25:0] i26, input logic [31:0] rs,
                              input logic [31:0] rt, input logic [31:0] epc,
                              input logic etk, input logic eflt);
    vec_t v;
    v.rst = rst; v.stl = stl; v.sel = sel; v.br = br; v.i16 = i16; v.i26 = i26;
    v.rs = rs; v.rt = rt; v.exp_pc = epc; v.exp_taken = etk; v.exp_fault = eflt;
    return v;
  endfunction

  function automatic logic m_taken(input vec_t v);
    logic c;
    case (v.br)
      2'b00:   c = (v.rs == v.rt);
      2'b01:   c = (v.rs != v.rt);
      2'b10:   c = v.rs[31] || (v.rs == 32'd0);
      default: c = !v.rs[31] && (v.rs != 32'd0);
    endcase
    return (v.sel == 2'b01) && c;
  endfunction

  function automatic logic [31:0] m_npc(input logic [31:0] p, input vec_t v);
    logic [31:0] p4, off;
    p4  = p + 32'd4;
    off = {{14{v.i16[15]}}, v.i16, 2'b00};
    case (v.sel)
      2'b00:   return p4;
      2'b01:   return m_taken(v) ? p4 + off : p4;
      2'b10:   return {p4[31:28], v.i26, 2'b00};
      default: return v.rs;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e, got;
    logic [31:0] nx;
    @(negedge clk);
    reset = v.rst; stall = v.stl; npc_sel = v.sel; br_type = v.br;
    imm16 = v.i16; imm26 = v.i26; rs_data = v.rs; rt_data = v.rt;
    #1;
    if (m_known) begin
      nx = m_npc(m_pc, v);
      if (!v.rst) begin
        chk("taken_tbl", {31'd0, taken}, {31'd0, v.exp_taken});
        chk("taken_mdl", {31'd0, taken}, {31'd0, m_taken(v)});
        chk("npc", npc, nx);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      end
    end else begin
      nx = 32'd0;
    end
    // advance the model and queue what the registers must show after the edge
    if (v.rst) begin
      m_known = 1'b1; m_pc = RPC; m_fault = 1'b0; m_faddr = 32'd0; m_cnt = 32'd0;
    end else if (m_fault || v.stl) begin
      // frozen
    end else if (nx[1:0] != 2'b00 || nx < RPC || nx >= LIM) begin
      m_fault = 1'b1; m_faddr = nx;
    end else begin
      m_pc = nx; m_cnt = m_cnt + 32'd1;
    end
    e.pc = m_pc; e.fault = m_fault; e.faddr = m_faddr; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = exp_q.pop_front();
      chk("pc", pc, got.pc);
      chk("fault", {31'd0, fault}, {31'd0, got.fault});
      chk("fault_addr", fault_addr, got.faddr);
      chk("retired_cnt", retired_cnt, got.cnt);
    end
    chk("pc_tbl", pc, v.exp_pc);
    chk("fault_tbl", {31'd0, fault}, {31'd0, v.exp_fault});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; npc_sel = 2'b00; br_type = 2'b00;
    imm16 = '0; imm26 = '0; rs_data = '0; rt_data = '0;

    // reset, sequential run, beq/bne, walk to 0x3020, jump, jr, illegal jr
    tbl1.push_back(mk(1,0,2'd0,2'd0,16'h0,26'h0,32'h0,32'h0,32'h3000,0,0));
    tbl1.push_back(mk(0,0,2'd0,2'd0,16'h0,26'h0,32'h0,32'h0,32'h3004,0,0));
    tbl1.push_back(mk(0,0,2'd0,2'd0,16'h0,26'h0,32'h0,32'h0,32'h3008,0,0));
    tbl1.push_back(mk(0,0,2'd0,2'd0,16'h0,26'h0,32'h0,32'h0,32'h300C,0,0));
    tbl1.push_back(mk(0,0,2'd0,2'd0,16'h0,26'h0,32'h0,32'h0,32'h3010,0,0));
    tbl1.push_back(mk(0,0,2'd1,2'd0,16'hFFFC,26'h0,32'h5,32'h5,32'h3004,1,0));
    tbl1.push_back(mk(0,0,2'd1,2'd1,16'h0008,26'h0,32'h5,32'h5,32'h3008,0,0));
    tbl1.push_back(mk(0,0,2'd0,2'd0,16'h0,26'h0,32'h0,32'h0,32'h300C,0,0));
    tbl1.push_back(mk(0,0,2'd0,2'd0,16'h0,26'h0,32'h0,32'h0,32'h3010,0,0));
    tbl1.push_back(mk(0,0,2'd0,2'd0,16'h0,26'h0,32'h0,32'h0,32'h3014,0,0));
    tbl1.push_back(mk(0,0,2'd0,2'd0,16'h0,26'h0,32'h0,32'h0,32'h3018,0,0));
    tbl1.push_back(mk(0,0,2'd0,2'd0,16'h0,26'h0,32'h0,32'h0,32'h301C,0,0));
    tbl1.push_back(mk(0,0,2'd0,2'd0,16'h0,26'h0,32'h0,32'h0,32'h3020,0,0));
    tbl1.push_back(mk(0,0,2'd2,2'd0,16'h0,26'h0000C40,32'h0,32'h0,32'h3100,0,0));
    tbl1.push_back(mk(0,0,2'd3,2'd0,16'h0,26'h0,32'h3020,32'h0,32'h3020,0,0));
    tbl1.push_back(mk(0,0,2'd3,2'd0,16'h0,26'h0,32'h3006,32'h0,32'h3020,0,1));

    // reset, stall with illegal target, release, signed compares, boundaries
    tbl2.push_back(mk(1,0,2'd0,2'd0,16'h0,26'h0,32'h0,32'h0,32'h3000,0,0));
    for (int i = 0; i < 4; i++)
      tbl2.push_back(mk(0,1,2'd3,2'd0,16'h0,26'h0,32'h9000,32'h0,32'h3000,0,0));
    tbl2.push_back(mk(0,0,2'd3,2'd0,16'h0,26'h0,32'h3040,32'h0,32'h3040,0,0));
    tbl2.push_back(mk(0,0,2'd1,2'd3,16'h0010,26'h0,32'h80000000,32'h0,32'h3044,0,0));
    tbl2.push_back(mk(0,0,2'd1,2'd2,16'h0004,26'h0,32'h0,32'h0,32'h3058,1,0));
    tbl2.push_back(mk(0,0,2'd3,2'd0,16'h0,26'h0,32'h7000,32'h0,32'h3058,0,1));
    tbl2.push_back(mk(1,1,2'd3,2'd0,16'h0,26'h0,32'h7000,32'h0,32'h3000,0,0));
    tbl2.push_back(mk(0,0,2'd3,2'd0,16'h0,26'h0,32'h6FFC,32'h0,32'h6FFC,0,0));
    tbl2.push_back(mk(0,0,2'd0,2'd0,16'h0,26'h0,32'h0,32'h0,32'h6FFC,0,1));
    tbl2.push_back(mk(1,0,2'd0,2'd0,16'h0,26'h0,32'h0,32'h0,32'h3000,0,0));
    tbl2.push_back(mk(0,0,2'd3,2'd0,16'h0,26'h0,32'h2FFC,32'h0,32'h3000,0,1));
    tbl2.push_back(mk(1,0,2'd0,2'd0,16'h0,26'h0,32'h0,32'h0,32'h3000,0,0));
    tbl2.push_back(mk(0,0,2'd1,2'd0,16'hFFFF,26'h0,32'h7,32'h7,32'h3000,1,0));
    tbl2.push_back(mk(0,0,2'd1,2'd3,16'h0003,26'h0,32'h1,32'h0,32'h3010,1,0));
    tbl2.push_back(mk(0,0,2'd1,2'd0,16'h0040,26'h0,32'h1,32'h2,32'h3014,0,0));
    tbl2.push_back(mk(0,0,2'd2,2'd0,16'h0,26'h3FFFFFF,32'h0,32'h0,32'h3014,0,1));
    tbl2.push_back(mk(1,0,2'd0,2'd0,16'h0,26'h0,32'h0,32'h0,32'h3000,0,0));

    foreach (tbl1[i]) step(tbl1[i]);

    // faulted: legal targets offered for several cycles must not move anything
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        step(mk(0,0,2'd0,2'd0,16'h0,26'h0,32'h0,32'h0,32'h3020,0,1));
      else
        step(mk(0,0,2'd3,2'd0,16'h0,26'h0,32'h3040,32'h0,32'h3020,0,1));
    end
    chk("fault_addr_held", fault_addr, 32'h3006);

    foreach (tbl2[i]) step(tbl2[i]);

    // long sequential run from reset checks the retire counter over many advances
    for (int i = 1; i <= 20; i++)
      step(mk(0,0,2'd0,2'd0,16'h0,26'h0,32'h0,32'h0,RPC + 32'(4*i),0,0));
    chk("retired_after_run", retired_cnt, 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
